// File: rtl/seq_restoring_divider_pkg.sv
// seq_restoring_divider_pkg: shared FSM state encoding and add/sub control encoding
package seq_restoring_divider_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;
endpackage

// File: rtl/seq_restoring_divider_addsub_nbit.sv
// addsub_nbit: ripple-carry N-bit adder/subtractor
//   a, b  operands
//   ctrl  ADD (0): a + b; SUB (1): a - b, b inverted with cin = 1
//   sum   N-bit result
//   cout  carry out; for SUB it is 1 when there is no borrow (a >= b)
module addsub_nbit #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ctrl,
  output logic [N-1:0] sum,
  output logic         cout
);
  logic [N-1:0] bx;
  logic [N:0]   c;
  assign bx   = b ^ {N{ctrl}};
  assign c[0] = ctrl;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]  = a[i] ^ bx[i] ^ c[i];
    assign c[i+1]  = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
  end
  assign cout = c[N];
endmodule

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: multi-cycle unsigned restoring divider with valid/ready handshakes
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake (dividend, divisor)
//   out_valid/out_ready        result handshake (quotient, remainder, div_by_zero)
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = $clog2(WIDTH + 1);
  state_t           state;
  logic [WIDTH-1:0] r, q, d;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_sh, trial;
  logic             nb, take;
  // Partial remainder stays below the divisor, so WIDTH bits hold it between steps;
  // only the shifted value needs the extra bit.
  assign r_sh = {r, q[WIDTH-1]};
  addsub_nbit #(.N(WIDTH + 1)) u_sub (
    .a    (r_sh),
    .b    ({1'b0, d}),
    .ctrl (SUB),
    .sum  (trial),
    .cout (nb)
  );
  // A no-borrow trial is always below the divisor, so its top bit is clear.
  assign take = nb & ~trial[WIDTH];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      r           <= '0;
      q           <= '0;
      d           <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid && in_ready) begin
          in_ready <= 1'b0;
          if (divisor == '0) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
          end else begin
            state <= CALC;
            d     <= divisor;
            r     <= '0;
            q     <= dividend;
            cnt   <= '0;
          end
        end
        CALC: if (cnt == CW'(WIDTH)) begin
          state       <= DONE;
          out_valid   <= 1'b1;
          quotient    <= q;
          remainder   <= r;
          div_by_zero <= 1'b0;
        end else begin
          r   <= take ? trial[WIDTH-1:0] : r_sh[WIDTH-1:0];
          q   <= {q[WIDTH-2:0], take};
          cnt <= cnt + 1'b1;
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: scoreboard bench for seq_restoring_divider against an arithmetic reference
module tb_seq_restoring_divider;
  localparam int W = 4;
  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
  } res_t;

  logic         clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         in_ready, out_valid, div_by_zero;
  logic [W-1:0] quotient, remainder;

  res_t sb[$];
  res_t exp_res;
  int   errors = 0, checks = 0, pops = 0, lat;
  bit   rand_ready = 0;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi;
    ai = int'(a);
    bi = int'(b);
    if (bi == 0) return '{q: '1, r: a, dbz: 1'b1};
    return '{q: W'(ai / bi), r: W'(ai % bi), dbz: 1'b0};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a result is consumed on the next rising edge when out_valid & out_ready.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got q=%0h r=%0h dbz=%0b with nothing expected",
                 quotient, remainder, div_by_zero);
      end else begin
        exp_res = sb.pop_front();
        pops++;
        check("result{q,r,dbz}", {23'd0, quotient, remainder, div_by_zero}, {23'd0, exp_res});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 200 cycles");
      return;
    end
    in_valid = 1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1 in_valid = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  logic [W-1:0] da[4] = '{4'd13, 4'd15, 4'd3, 4'd0};
  logic [W-1:0] db[4] = '{4'd4, 4'd1, 4'd9, 4'd5};

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    rst_n = 1;
    out_ready = 1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      send(da[i], db[i]);
      wait_valid(lat);
      check("latency", lat, W + 1);
      @(posedge clk);
      #1;
      check("return_out_valid", out_valid, 0);
      check("return_in_ready", in_ready, 1);
    end

    send(4'd7, 4'd0);
    wait_valid(lat);
    check("dbz_latency", lat, 0);
    @(posedge clk);
    #1;
    check("dbz_return_in_ready", in_ready, 1);

    out_ready = 0;
    send(4'd9, 4'd2);
    wait_valid(lat);
    check("stall_latency", lat, W + 1);
    for (int k = 0; k < 10; k++) begin
      in_valid = 1;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_hold", {quotient, remainder, div_by_zero}, {4'd4, 4'd1, 1'b0});
    end
    in_valid = 0;
    out_ready = 1;
    @(posedge clk);
    #1;
    check("stall_release_out_valid", out_valid, 0);
    check("stall_no_extra", sb.size(), 0);

    send(4'd13, 4'd4);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 0;
    #1;
    sb.delete();
    check("midcalc_rst_in_ready", in_ready, 1);
    check("midcalc_rst_out_valid", out_valid, 0);
    check("midcalc_rst_q_r", {quotient, remainder}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (8) begin
      @(posedge clk);
      #1;
    end
    check("post_rst_out_valid", out_valid, 0);

    pops = 0;
    rand_ready = 1;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send(W'(a), W'(b));
      end
    for (int t = 0; t < 2000 && sb.size() > 0; t++) begin
      @(posedge clk);
      #1;
    end
    rand_ready = 0;
    out_ready = 1;
    check("drain_empty", sb.size(), 0);
    check("exhaustive_count", pops, 256);
    repeat (5) @(posedge clk);
    #1;
    check("final_idle", {out_valid, in_ready}, 2'b01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
